// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement buffer with tag-indexed writeback and operand read port
module reorder_buffer #(
  parameter int ROB_SIZE  = 18,
  parameter int IDX_W     = 5,
  parameter int DATA_W    = 64,
  parameter int GPR_IDX_W = 5
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 flush_in,
  input  logic                 alloc_valid_in,
  input  logic [GPR_IDX_W-1:0] alloc_gpr_index_in,
  input  logic                 alloc_set_nzcv_in,
  output logic                 alloc_ready_out,
  output logic [IDX_W-1:0]     alloc_rob_index_out,
  input  logic                 wb_valid_in,
  input  logic [IDX_W-1:0]     wb_rob_index_in,
  input  logic [DATA_W-1:0]    wb_value_in,
  input  logic [3:0]           wb_nzcv_in,
  input  logic [IDX_W-1:0]     rd_rob_index_in,
  output logic                 rd_valid_out,
  output logic [DATA_W-1:0]    rd_value_out,
  output logic                 commit_valid_out,
  output logic [IDX_W-1:0]     commit_rob_index_out,
  output logic [GPR_IDX_W-1:0] commit_gpr_index_out,
  output logic [DATA_W-1:0]    commit_value_out,
  output logic                 commit_set_nzcv_out,
  output logic [3:0]           commit_nzcv_out,
  output logic                 empty_out
);

  localparam logic [IDX_W:0]   FULL_COUNT = (IDX_W+1)'(ROB_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(ROB_SIZE - 1);

  logic [GPR_IDX_W-1:0] ent_gpr   [ROB_SIZE];
  logic [DATA_W-1:0]    ent_value [ROB_SIZE];
  logic [3:0]           ent_nzcv  [ROB_SIZE];
  logic [ROB_SIZE-1:0]  ent_set_nzcv;
  logic [ROB_SIZE-1:0]  ent_alloc;
  logic [ROB_SIZE-1:0]  ent_valid;

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W:0]   count;

  logic alloc_fire;
  logic commit_fire;
  logic wb_in_range;
  logic wb_hit;
  logic rd_in_range;
  logic rd_fwd;

  // Size need not be a power of two, so wrap is an explicit compare.
  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  assign alloc_ready_out     = (count != FULL_COUNT);
  assign alloc_rob_index_out = tail;
  assign empty_out           = (count == '0);
  assign alloc_fire          = alloc_valid_in & alloc_ready_out;
  // Commit looks only at registered valid, so a writeback retires one edge later at the earliest.
  assign commit_fire         = (count != '0) & ent_valid[head];
  assign wb_in_range         = ({1'b0, wb_rob_index_in} < FULL_COUNT);
  assign wb_hit              = wb_valid_in & wb_in_range & ent_alloc[wb_rob_index_in];
  assign rd_in_range         = ({1'b0, rd_rob_index_in} < FULL_COUNT);

  always_comb begin
    rd_fwd       = 1'b0;
    rd_valid_out = 1'b0;
    rd_value_out = '0;
    if (rd_in_range) begin
      rd_fwd       = wb_valid_in & (wb_rob_index_in == rd_rob_index_in) & ent_alloc[rd_rob_index_in];
      rd_valid_out = (ent_alloc[rd_rob_index_in] & ent_valid[rd_rob_index_in]) | rd_fwd;
      rd_value_out = rd_fwd ? wb_value_in : ent_value[rd_rob_index_in];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head                 <= '0;
      tail                 <= '0;
      count                <= '0;
      ent_alloc            <= '0;
      ent_valid            <= '0;
      ent_set_nzcv         <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        ent_gpr[i]   <= '0;
        ent_value[i] <= '0;
        ent_nzcv[i]  <= '0;
      end
      commit_valid_out     <= 1'b0;
      commit_rob_index_out <= '0;
      commit_gpr_index_out <= '0;
      commit_value_out     <= '0;
      commit_set_nzcv_out  <= 1'b0;
      commit_nzcv_out      <= '0;
    end else if (flush_in) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      ent_alloc        <= '0;
      ent_valid        <= '0;
      commit_valid_out <= 1'b0;
    end else begin
      commit_valid_out <= commit_fire;
      if (commit_fire) begin
        commit_rob_index_out <= head;
        commit_gpr_index_out <= ent_gpr[head];
        commit_value_out     <= ent_value[head];
        commit_set_nzcv_out  <= ent_set_nzcv[head];
        commit_nzcv_out      <= ent_nzcv[head];
        ent_alloc[head]      <= 1'b0;
        ent_valid[head]      <= 1'b0;
        head                 <= next_ptr(head);
      end
      if (wb_hit) begin
        ent_value[wb_rob_index_in] <= wb_value_in;
        ent_nzcv[wb_rob_index_in]  <= wb_nzcv_in;
        ent_valid[wb_rob_index_in] <= 1'b1;
      end
      // The tail slot is never allocated while not full, so it cannot collide with a writeback.
      if (alloc_fire) begin
        ent_gpr[tail]      <= alloc_gpr_index_in;
        ent_set_nzcv[tail] <= alloc_set_nzcv_in;
        ent_valid[tail]    <= 1'b0;
        ent_alloc[tail]    <= 1'b1;
        tail               <= next_ptr(tail);
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed bench for reorder_buffer with an in-order retire scoreboard
module tb_reorder_buffer;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        alloc_valid;
  logic [4:0]  alloc_gpr;
  logic        alloc_set_nzcv;
  logic        alloc_ready;
  logic [4:0]  alloc_idx;
  logic        wb_valid;
  logic [4:0]  wb_idx;
  logic [63:0] wb_value;
  logic [3:0]  wb_nzcv;
  logic [4:0]  rd_idx;
  logic        rd_valid;
  logic [63:0] rd_value;
  logic        c_valid;
  logic [4:0]  c_idx;
  logic [4:0]  c_gpr;
  logic [63:0] c_value;
  logic        c_set_nzcv;
  logic [3:0]  c_nzcv;
  logic        empty;

  int n_assert = 0;
  int n_fail   = 0;

  // Program-order model: queue of expected retire indices plus per-index fields.
  int          m_q[$];
  logic [4:0]  m_gpr  [32];
  logic [63:0] m_val  [32];
  logic [3:0]  m_nzcv [32];
  logic        m_set  [32];

  reorder_buffer dut (
    .clk_in               (clk),
    .rst_in               (rst),
    .flush_in             (flush),
    .alloc_valid_in       (alloc_valid),
    .alloc_gpr_index_in   (alloc_gpr),
    .alloc_set_nzcv_in    (alloc_set_nzcv),
    .alloc_ready_out      (alloc_ready),
    .alloc_rob_index_out  (alloc_idx),
    .wb_valid_in          (wb_valid),
    .wb_rob_index_in      (wb_idx),
    .wb_value_in          (wb_value),
    .wb_nzcv_in           (wb_nzcv),
    .rd_rob_index_in      (rd_idx),
    .rd_valid_out         (rd_valid),
    .rd_value_out         (rd_value),
    .commit_valid_out     (c_valid),
    .commit_rob_index_out (c_idx),
    .commit_gpr_index_out (c_gpr),
    .commit_value_out     (c_value),
    .commit_set_nzcv_out  (c_set_nzcv),
    .commit_nzcv_out      (c_nzcv),
    .empty_out            (empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (c_valid === 1'b1) begin
      if (m_q.size() == 0) begin
        check("commit_unexpected", 64'(c_valid), 64'd0);
      end else begin
        int e;
        e = m_q.pop_front();
        check("sb_idx", 64'(c_idx), 64'(e));
        check("sb_gpr", 64'(c_gpr), 64'(m_gpr[e]));
        check("sb_value", c_value, m_val[e]);
        check("sb_set_nzcv", 64'(c_set_nzcv), 64'(m_set[e]));
        check("sb_nzcv", 64'(c_nzcv), 64'(m_nzcv[e]));
      end
    end
  end

  task automatic do_alloc(input logic [4:0] gpr, input logic setn, input int exp_idx);
    alloc_valid    = 1'b1;
    alloc_gpr      = gpr;
    alloc_set_nzcv = setn;
    #1;
    check("alloc_ready", 64'(alloc_ready), 64'd1);
    check("alloc_idx", 64'(alloc_idx), 64'(exp_idx));
    tick();
    alloc_valid    = 1'b0;
    alloc_set_nzcv = 1'b0;
    m_gpr[exp_idx] = gpr;
    m_set[exp_idx] = setn;
    m_q.push_back(exp_idx);
  endtask

  task automatic do_wb(input int idx, input logic [63:0] val, input logic [3:0] nz);
    wb_valid     = 1'b1;
    wb_idx       = 5'(idx);
    wb_value     = val;
    wb_nzcv      = nz;
    m_val[idx]   = val;
    m_nzcv[idx]  = nz;
    tick();
    wb_valid     = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    m_q.delete();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    alloc_valid = 1'b0; alloc_gpr = '0; alloc_set_nzcv = 1'b0;
    wb_valid = 1'b0; wb_idx = '0; wb_value = '0; wb_nzcv = '0; rd_idx = '0;
    #12;
    check("rst_ready", 64'(alloc_ready), 64'd1);
    check("rst_alloc_idx", 64'(alloc_idx), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_commit_valid", 64'(c_valid), 64'd0);
    check("rst_commit_value", c_value, 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_value", rd_value, 64'd0);
    rst = 1'b0;
    tick();

    // Three allocations return 0,1,2 and nothing retires.
    do_alloc(5'd1, 1'b0, 0);
    do_alloc(5'd2, 1'b0, 1);
    do_alloc(5'd3, 1'b0, 2);
    check("t1_empty", 64'(empty), 64'd0);
    check("t1_no_commit", 64'(c_valid), 64'd0);

    // Out-of-order writebacks retire in order on consecutive edges; idx2 stalls.
    do_wb(1, 64'hAA, 4'h0);
    check("t2_hold_idx1", 64'(c_valid), 64'd0);
    do_wb(0, 64'h55, 4'h0);
    check("t2_latency", 64'(c_valid), 64'd0);
    tick();
    check("t2_c0_valid", 64'(c_valid), 64'd1);
    check("t2_c0_idx", 64'(c_idx), 64'd0);
    tick();
    check("t2_c1_valid", 64'(c_valid), 64'd1);
    check("t2_c1_idx", 64'(c_idx), 64'd1);
    tick();
    check("t2_idx2_stall", 64'(c_valid), 64'd0);
    do_flush();
    check("flush_empty", 64'(empty), 64'd1);

    // Fill all 18 entries, then a 19th request is refused.
    for (int i = 0; i < 18; i++) do_alloc(5'(i + 1), 1'b0, i);
    alloc_valid = 1'b1;
    #1;
    check("full_ready", 64'(alloc_ready), 64'd0);
    check("full_tail_wrap", 64'(alloc_idx), 64'd0);
    tick();
    alloc_valid = 1'b0;
    #1;
    check("full_tail_hold", 64'(alloc_idx), 64'd0);
    check("full_ready_hold", 64'(alloc_ready), 64'd0);

    // Same-cycle writeback is forwarded to the read port.
    rd_idx = 5'd4;
    #1;
    check("rd_pending", 64'(rd_valid), 64'd0);
    wb_valid = 1'b1; wb_idx = 5'd4; wb_value = 64'h1234; wb_nzcv = 4'h0;
    m_val[4] = 64'h1234; m_nzcv[4] = 4'h0;
    #1;
    check("rd_fwd_valid", 64'(rd_valid), 64'd1);
    check("rd_fwd_value", rd_value, 64'h1234);
    tick();
    wb_valid = 1'b0;
    #1;
    check("rd_stored_valid", 64'(rd_valid), 64'd1);
    check("rd_stored_value", rd_value, 64'h1234);
    rd_idx = 5'd20;
    #1;
    check("rd_out_of_range", 64'(rd_valid), 64'd0);

    // Completing the head frees a slot only after the commit edge.
    do_wb(0, 64'hC0DE, 4'h0);
    check("full_commit_cycle_ready", 64'(alloc_ready), 64'd0);
    tick();
    check("full_commit", 64'(c_valid), 64'd1);
    check("full_ready_again", 64'(alloc_ready), 64'd1);
    do_alloc(5'd9, 1'b0, 0);
    check("full_again", 64'(alloc_ready), 64'd0);
    do_flush();

    // NZCV propagation, then a dropped writeback to an unallocated entry.
    do_alloc(5'd7, 1'b1, 0);
    do_wb(0, 64'h77, 4'b0100);
    tick();
    check("nz_valid", 64'(c_valid), 64'd1);
    check("nz_set", 64'(c_set_nzcv), 64'd1);
    check("nz_flags", 64'(c_nzcv), 64'b0100);
    tick();
    wb_valid = 1'b1; wb_idx = 5'd9; wb_value = 64'h99; rd_idx = 5'd9;
    #1;
    check("unalloc_rd", 64'(rd_valid), 64'd0);
    tick();
    wb_valid = 1'b0;
    check("unalloc_no_commit", 64'(c_valid), 64'd0);
    check("unalloc_empty", 64'(empty), 64'd1);

    // Flush wins over a simultaneous alloc, writeback and commit.
    for (int i = 1; i <= 5; i++) do_alloc(5'(10 + i), 1'b0, i);
    do_wb(1, 64'h111, 4'h0);
    flush = 1'b1; alloc_valid = 1'b1; wb_valid = 1'b1; wb_idx = 5'd2; wb_value = 64'h222;
    tick();
    flush = 1'b0; alloc_valid = 1'b0; wb_valid = 1'b0;
    m_q.delete();
    check("flush_commit_valid", 64'(c_valid), 64'd0);
    check("flush_all_empty", 64'(empty), 64'd1);
    check("flush_alloc_idx", 64'(alloc_idx), 64'd0);
    do_alloc(5'd3, 1'b0, 0);
    check("post_flush_empty", 64'(empty), 64'd0);

    // Asynchronous reset in mid-cycle clears outputs before the next edge.
    do_alloc(5'd4, 1'b0, 1);
    do_wb(0, 64'hBEEF, 4'h0);
    tick();
    check("pre_rst_commit", 64'(c_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_commit_valid", 64'(c_valid), 64'd0);
    check("arst_commit_value", c_value, 64'd0);
    check("arst_empty", 64'(empty), 64'd1);
    check("arst_alloc_idx", 64'(alloc_idx), 64'd0);
    m_q.delete();
    #1;
    rst = 1'b0;
    tick();
    check("post_rst_ready", 64'(alloc_ready), 64'd1);

    for (int i = 0; i < 20 && m_q.size() != 0; i++) tick();
    check("sb_drained", 64'(m_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
In-order retirement buffer for the Tomasulo core. Decode allocates an entry at the tail and gets back a ROB index to tag the destination. FU writebacks (ALU/LS) are written into entries by ROB index. Completed entries at the head retire one per cycle toward the GPR file and the NZCV register, and a combinational read port serves operand lookups for reservation-station dispatch.

Parameters:
ROB_SIZE, 18 (`ROB_SIZE), number of entries; need not be a power of two
IDX_W, 5 (`ROB_IDX_SIZE), ROB index width
DATA_W, 64 (`GPR_SIZE), result value width
GPR_IDX_W, 5 (`GPR_IDX_SIZE), architectural register index width

Ports:
clk_in  in  1  clock
rst_in  in  1  asynchronous active-high reset
flush_in  in  1  squash all entries (mispredict)
alloc_valid_in  in  1  decode requests an entry
alloc_gpr_index_in  in  GPR_IDX_W  destination GPR
alloc_set_nzcv_in  in  1  instruction writes NZCV
alloc_ready_out  out  1  entry available this cycle
alloc_rob_index_out  out  IDX_W  index granted (current tail)
wb_valid_in  in  1  FU result valid
wb_rob_index_in  in  IDX_W  entry being completed
wb_value_in  in  DATA_W  result value
wb_nzcv_in  in  4  flags (nzcv_t)
rd_rob_index_in  in  IDX_W  operand lookup index
rd_valid_out  out  1  looked-up entry has its value
rd_value_out  out  DATA_W  looked-up value
commit_valid_out  out  1  registered retire pulse
commit_rob_index_out  out  IDX_W  retired entry index
commit_gpr_index_out  out  GPR_IDX_W  GPR to write
commit_value_out  out  DATA_W  value to write
commit_set_nzcv_out  out  1  NZCV update enable
commit_nzcv_out  out  4  flags to write
empty_out  out  1  count == 0

Behaviour:
- State: entry array of rob_entry_t plus per-entry allocated bit; head, tail in [0, ROB_SIZE-1]; count in [0, ROB_SIZE] (IDX_W+1 bits).
- Reset (async, rst_in=1): head=tail=count=0; all allocated and valid bits = 0; commit_* = 0; alloc_ready_out=1; empty_out=1; rd_* = 0.
- Wrap: pointer increments from ROB_SIZE-1 to 0 with explicit compare; no modulo-by-power-of-two.
- Allocate: alloc_ready_out = (count != ROB_SIZE). Same-cycle commit does not free a slot for allocation. alloc_rob_index_out = tail, combinational.
  - On posedge with alloc_valid_in & alloc_ready_out: entry[tail] ← {gpr, valid=0, set_nzcv}, allocated=1; tail advances.
  - alloc_valid_in while full is ignored; no state changes.
- Writeback: on posedge with wb_valid_in, if entry[wb_rob_index_in] is allocated, store value and nzcv and set valid=1. Writeback to an unallocated index is dropped.
- Commit: each cycle, if count != 0 and entry[head].valid (registered state, not this cycle's wb), then on posedge:
  - commit_valid_out=1 with that entry's fields;
  - entry[head].allocated=0; head advances.
  - Otherwise commit_valid_out=0 next cycle; other commit_* hold their last values.
  - Latency: writeback at edge N commits at edge N+1 at the earliest, so commit_valid_out is visible after edge N+1.
- Count: +1 on alloc only, -1 on commit only, unchanged when both or neither happen.
- Read port, combinational:
  - rd_valid_out = allocated & valid for rd_rob_index_in, OR (wb_valid_in & wb_rob_index_in == rd_rob_index_in & allocated), which forwards the same-cycle writeback.
  - rd_value_out uses the forwarded value when forwarding, else the stored value.
  - Out-of-range index (≥ ROB_SIZE) returns rd_valid_out=0.
- Flush: synchronous, highest priority. On posedge with flush_in: head=tail=count=0, all allocated/valid cleared, commit_valid_out=0. Alloc, wb and commit in that cycle are discarded.
- Reset mid-operation clears state immediately, regardless of clock.

Test Plan:
- Reset, then alloc 3 (gpr 1,2,3) → indices 0,1,2 returned; count=3; empty_out=0; no commit.
- Writeback idx1 value 0xAA then idx0 value 0x55 → commit order idx0 (gpr1, 0x55) then idx1 (gpr2, 0xAA), on consecutive cycles; idx2 stalls at the head.
- Alloc 18 with no writebacks → alloc_ready_out=0 on the 19th request; tail unchanged. Complete idx0 and commit → alloc_ready_out=1 again; next alloc returns 0 after the tail wrap from 17.
- With wb_valid_in on idx4 (value 0x1234) and rd_rob_index_in=4 in the same cycle → rd_valid_out=1, rd_value_out=0x1234 before the edge.
- Alloc with set_nzcv=1, writeback nzcv=4'b0100 → commit_set_nzcv_out=1, commit_nzcv_out=4'b0100. Writeback to an unallocated idx 9 → no effect.
- Flush asserted together with alloc+wb+commit on 5 live entries → count=0, empty_out=1, commit_valid_out=0. Next alloc returns idx0. Asserting rst_in mid-cycle clears outputs before the next edge.
